mem_pattern_master: RTL and testbench

- Bus initiator that drives the req/gnt/rvalid memory protocol used by the core-side instruction and data ports, from the master side.
- On start, it writes a seeded pseudo-random pattern to a contiguous word region, then reads the region back and compares each word.
- Reports pass/fail, error count and first failing address.
- Sits in the sanity SoC in place of, or muxed with, the core data port. It is used for memory bring-up and self-test of sp_ram instances.

---
 rtl/mem_pattern_master.sv | 128 ++++++++++++
 tb/tb_mem_pattern_master.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_pattern_master.sv
// Memory self-test initiator: writes a seeded pattern over a word region,
// reads it back over req/gnt/rvalid and reports pass, error count and first bad address.
module mem_pattern_master #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
   parameter int unsigned NUM_WORDS = 256,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [31:0]           seed_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pass_o,
   output logic                  timeout_o,
   output logic [15:0]           err_count_o,
   output logic [ADDR_WIDTH-1:0] first_err_addr_o,
   output logic                  req_o,
   input  logic                  gnt_i,
   input  logic                  rvalid_i,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  we_o,
   output logic [3:0]            be_o,
   output logic [DATA_WIDTH-1:0] wdata_o,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   input  logic                  err_i
);

   typedef enum logic [2:0] {
      IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE
   } state_t;

   localparam logic [15:0] LAST_K   = 16'(NUM_WORDS - 1);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   localparam logic [31:0] GOLDEN   = 32'h9E3779B9;

   state_t                  state_q, state_d;
   logic [15:0]             k_q;
   logic [15:0]             tmo_q;
   logic [31:0]             seed_q;
   logic [DATA_WIDTH-1:0]   pattern;
   logic [ADDR_WIDTH-1:0]   word_addr;
   logic                    in_req, in_wait, hs, expire, fail, last, accept;

   assign pattern   = DATA_WIDTH'(seed_q ^ (32'(k_q) * GOLDEN));
   assign word_addr = BASE_ADDR + ADDR_WIDTH'({k_q, 2'b00});

   assign in_req  = (state_q == WR_REQ) || (state_q == RD_REQ);
   assign in_wait = (state_q == WR_WAIT) || (state_q == RD_WAIT);
   assign hs      = (in_req && gnt_i) || (in_wait && rvalid_i);
   // a response landing in the last allowed cycle still wins over the abort
   assign expire  = (in_req || in_wait) && (tmo_q == TMO_LAST) && !hs;
   assign last    = (k_q == LAST_K);
   assign accept  = (state_q == IDLE) && start_i;
   assign fail    = in_wait && rvalid_i &&
                    (err_i || ((state_q == RD_WAIT) && (rdata_i != pattern)));

   assign req_o   = in_req;
   assign we_o    = (state_q == WR_REQ);
   assign be_o    = in_req ? 4'b1111 : 4'b0000;
   assign addr_o  = in_req ? word_addr : '0;
   assign wdata_o = we_o ? pattern : '0;

   always_comb begin
      state_d = state_q;
      if (expire) begin
         state_d = DONE;
      end else begin
         unique case (state_q)
            IDLE:    if (start_i) state_d = WR_REQ;
            WR_REQ:  if (gnt_i) state_d = WR_WAIT;
            WR_WAIT: if (rvalid_i) state_d = last ? RD_REQ : WR_REQ;
            RD_REQ:  if (gnt_i) state_d = RD_WAIT;
            RD_WAIT: if (rvalid_i) state_d = last ? DONE : RD_REQ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q          <= IDLE;
         k_q              <= '0;
         tmo_q            <= '0;
         seed_q           <= '0;
         busy_o           <= 1'b0;
         done_o           <= 1'b0;
         pass_o           <= 1'b0;
         timeout_o        <= 1'b0;
         err_count_o      <= '0;
         first_err_addr_o <= '0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q) tmo_q <= '0;
         else if (in_req || in_wait) tmo_q <= tmo_q + 16'd1;

         if (accept) begin
            seed_q           <= seed_i;
            k_q              <= '0;
            busy_o           <= 1'b1;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            timeout_o        <= 1'b0;
            err_count_o      <= '0;
            first_err_addr_o <= '0;
         end

         if (in_wait && rvalid_i) k_q <= last ? 16'd0 : k_q + 16'd1;

         if (fail) begin
            if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
            if (err_count_o == 16'd0) first_err_addr_o <= word_addr;
         end

         if (expire) timeout_o <= 1'b1;

         if (state_q == DONE) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            pass_o <= (err_count_o == 16'd0) && !timeout_o;
         end
      end
   end

endmodule

// File: tb/tb_mem_pattern_master.sv
// Bench for mem_pattern_master: behavioural 4-word slave with fault knobs,
// table of scenarios plus reset and busy-start sequences.
module tb_mem_pattern_master;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic [31:0] seed_i = '0;
   logic        busy_o, done_o, pass_o, timeout_o;
   logic [15:0] err_count_o;
   logic [31:0] first_err_addr_o;
   logic        req_o, we_o;
   logic        gnt_i = 1'b0, rvalid_i = 1'b0, err_i = 1'b0;
   logic [31:0] addr_o, wdata_o;
   logic [31:0] rdata_i = '0;
   logic [3:0]  be_o;

   mem_pattern_master #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0),
      .NUM_WORDS(4), .TIMEOUT(5)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .seed_i(seed_i),
      .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
      .timeout_o(timeout_o), .err_count_o(err_count_o),
      .first_err_addr_o(first_err_addr_o), .req_o(req_o), .gnt_i(gnt_i),
      .rvalid_i(rvalid_i), .addr_o(addr_o), .we_o(we_o), .be_o(be_o),
      .wdata_o(wdata_o), .rdata_i(rdata_i), .err_i(err_i)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   // slave configuration and state
   int          gnt_delay = 0;
   int          corrupt = -1;
   bit          no_rvalid = 0;
   bit          err_wr = 0;
   logic [31:0] mem [4];
   int          gcnt = 0;
   bit          pend = 0, pend_we = 0, waiting = 0;
   logic [31:0] pend_data = '0;
   logic [31:0] p_addr = '0, p_wdata = '0;
   logic        p_we = 1'b0;
   int          rd_gnts = 0;
   int          first_gnt = -1;

   always @(negedge clk) begin
      int idx;
      gnt_i = 1'b0; rvalid_i = 1'b0; err_i = 1'b0; rdata_i = '0;
      if (!rst_ni) begin
         pend = 0; gcnt = 0; waiting = 0;
      end else begin
         if (pend && !no_rvalid) begin
            rvalid_i = 1'b1;
            err_i    = pend_we && err_wr;
            rdata_i  = pend_we ? 32'h0 : pend_data;
         end
         pend = 0;
         if (req_o) begin
            if (waiting) begin
               n_chk++;
               if (addr_o !== p_addr || wdata_o !== p_wdata || we_o !== p_we) begin
                  n_err++;
                  $display("FAIL stable addr %h/%h wdata %h/%h we %b/%b",
                           addr_o, p_addr, wdata_o, p_wdata, we_o, p_we);
               end
            end
            if (gcnt == gnt_delay) begin
               chk("be_on_req", 64'(be_o), 64'hF);
               gnt_i = 1'b1; gcnt = 0; waiting = 0;
               if (first_gnt < 0) first_gnt = cyc;
               idx = int'(addr_o[3:2]);
               if (we_o) mem[idx] = wdata_o;
               else begin
                  rd_gnts++;
                  pend_data = mem[idx] ^ ((idx == corrupt) ? 32'h1 : 32'h0);
               end
               pend = 1; pend_we = we_o;
            end else begin
               gcnt++; waiting = 1;
               p_addr = addr_o; p_wdata = wdata_o; p_we = we_o;
            end
         end
      end
   end

   typedef struct {
      logic [31:0] seed;
      int          gdly;
      int          corrupt;
      bit          norv;
      bit          errwr;
      bit          pass;
      bit          tmo;
      logic [15:0] errs;
      logic [31:0] first;
      int          lat;
   } vec_t;

   task automatic run_test(input logic [31:0] seed, input int bp,
                           output int lat);
      int t0, n;
      @(negedge clk);
      seed_i = seed; start_i = 1'b1; t0 = cyc;
      @(negedge clk);
      start_i = 1'b0;
      chk("busy_after_start", 64'(busy_o), 64'h1);
      n = 0;
      while (!done_o && n < 300) begin
         if (n == bp) begin start_i = 1'b1; seed_i = ~seed; end
         else start_i = 1'b0;
         @(negedge clk);
         n++;
      end
      start_i = 1'b0;
      chk("done_reached", 64'(done_o), 64'h1);
      chk("busy_at_done", 64'(busy_o), 64'h0);
      lat = cyc - t0;
   endtask

   vec_t v[5];

   initial begin
      int lat, tdone;
      v[0] = '{32'h0,        0, -1, 0, 0, 1, 0, 16'd0, 32'h0, 18};
      v[1] = '{32'h0,        0,  2, 0, 0, 0, 0, 16'd1, 32'h8, -1};
      v[2] = '{32'h12345678, 3, -1, 0, 0, 1, 0, 16'd0, 32'h0, -1};
      v[3] = '{32'hA5A5A5A5, 0, -1, 0, 1, 0, 0, 16'd4, 32'h0, -1};
      v[4] = '{32'h0,        0, -1, 1, 0, 0, 1, 16'd0, 32'h0, -1};

      repeat (2) @(negedge clk);
      chk("reset_outputs",
          {busy_o, done_o, pass_o, timeout_o, req_o, we_o, be_o, err_count_o},
          64'h0);
      chk("reset_addr_data", {addr_o, wdata_o}, 64'h0);
      chk("reset_first", 64'(first_err_addr_o), 64'h0);
      rst_ni = 1'b1;

      for (int i = 0; i < 5; i++) begin
         gnt_delay = v[i].gdly; corrupt = v[i].corrupt;
         no_rvalid = v[i].norv; err_wr = v[i].errwr;
         first_gnt = -1; gcnt = 0;
         for (int j = 0; j < 4; j++) mem[j] = 32'hDEADBEEF;
         run_test(v[i].seed, -1, lat);
         tdone = cyc;
         chk($sformatf("v%0d_pass", i), 64'(pass_o), 64'(v[i].pass));
         chk($sformatf("v%0d_timeout", i), 64'(timeout_o), 64'(v[i].tmo));
         chk($sformatf("v%0d_errs", i), 64'(err_count_o), 64'(v[i].errs));
         chk($sformatf("v%0d_first", i), 64'(first_err_addr_o), 64'(v[i].first));
         if (v[i].lat >= 0)
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(v[i].lat));
         if (v[i].tmo) begin
            chk("tmo_within_7", 64'((tdone - first_gnt) <= 7), 64'h1);
            chk("tmo_req_low", 64'(req_o), 64'h0);
         end
         if (i == 0) begin
            chk("mem0", 64'(mem[0]), 64'h0);
            chk("mem1", 64'(mem[1]), 64'h9E3779B9);
            chk("mem2", 64'(mem[2]), 64'h3C6EF372);
            chk("mem3", 64'(mem[3]), 64'hDAA66D2B);
         end
         repeat (2) @(negedge clk);
      end

      // reset asserted during RD_WAIT of word 1
      gnt_delay = 0; corrupt = -1; no_rvalid = 0; err_wr = 0;
      gcnt = 0; rd_gnts = 0;
      @(negedge clk);
      seed_i = 32'hC0FFEE00; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int n = 0; n < 100 && rd_gnts < 2; n++) begin
         @(negedge clk);
         #1;
      end
      chk("reached_rd1", 64'(rd_gnts), 64'd2);
      @(negedge clk);
      #1 rst_ni = 1'b0;
      #1;
      chk("midreset_ctrl",
          {busy_o, done_o, pass_o, timeout_o, req_o, we_o, be_o, err_count_o},
          64'h0);
      chk("midreset_bus", {addr_o, wdata_o}, 64'h0);
      @(negedge clk);
      #2 rst_ni = 1'b1;

      // rerun with a start pulse while busy: must not restart
      run_test(32'h0BADF00D, 4, lat);
      chk("rerun_pass", 64'(pass_o), 64'h1);
      chk("rerun_latency", 64'(lat), 64'd18);
      chk("rerun_errs", 64'(err_count_o), 64'h0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
